// File: rtl/rr_req_ack_sched.sv
// Round-robin scheduler sharing one req/ack responder among N_REQ clients.
// Captures req rising edges as pending jobs and serves one at a time.
module rr_req_ack_sched #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 15,
    parameter int IDW     = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] ack,
    output logic             res_start,
    output logic [IDW-1:0]   res_id,
    input  logic             res_done,
    output logic             busy,
    output logic             timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, ACK} state_t;

    state_t           state, state_n;
    logic [N_REQ-1:0] req_q;
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] rise;
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] id_oh;
    logic [CW-1:0]    cnt;
    logic [IDW-1:0]   last;
    logic [IDW-1:0]   sel_n;
    logic             found;
    logic             expire;
    int               idx;

    assign rise   = req & ~req_q;
    assign id_oh  = N_REQ'(1) << res_id;
    assign clr    = (state == START) ? id_oh : '0;
    assign expire = (state == WAIT) && !res_done && (cnt == CNT_MAX);

    // First pending requester after the last one served, wrapping around.
    always_comb begin
        found = 1'b0;
        sel_n = '0;
        idx   = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            idx = (int'(last) + off) % N_REQ;
            if (!found && pending[idx]) begin
                found = 1'b1;
                sel_n = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (found) state_n = START;
            START: state_n = WAIT;
            WAIT: begin
                if (res_done)
                    state_n = ACK;
                else if (cnt == CNT_MAX)
                    state_n = IDLE;
            end
            ACK:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            req_q       <= '0;
            pending     <= '0;
            cnt         <= '0;
            last        <= IDW'(N_REQ - 1);
            res_id      <= '0;
            res_start   <= 1'b0;
            ack         <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            req_q       <= req;
            // A rise on the clearing edge keeps the new job.
            pending     <= (pending & ~clr) | rise;
            res_start   <= (state == IDLE) && found;
            busy        <= (state_n != IDLE);
            ack         <= (state == WAIT && res_done) ? id_oh : '0;
            timeout_err <= expire;
            if (state == IDLE && found)
                res_id <= sel_n;
            if (state == START)
                cnt <= '0;
            else if (state == WAIT && !res_done && cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
            if (state == ACK || expire)
                last <= res_id;
        end
    end

endmodule

// File: tb/tb_rr_req_ack_sched.sv
// Randomized bench for rr_req_ack_sched: timeline model + event scoreboard.
module tb_rr_req_ack_sched;

    localparam int N   = 4;
    localparam int T   = 15;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   ack;
    logic           res_start;
    logic [IDW-1:0] res_id;
    logic           res_done;
    logic           busy;
    logic           timeout_err;

    always #5 clk = ~clk;

    rr_req_ack_sched #(.N_REQ(N), .TIMEOUT(T)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .ack(ack),
        .res_start(res_start),
        .res_id(res_id),
        .res_done(res_done),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    int checks = 0;
    int errors = 0;

    // Expected events: kind 0 = start, 1 = ack, 2 = timeout
    int exp_kind[$];
    int exp_id[$];

    // Reference model: jobs on an edge-numbered timeline
    bit [N-1:0] m_pend;
    logic [N-1:0] m_rq;
    int  m_last, m_sel, m_pick, m_done_at, m_free, edge_n;
    bit  m_act;
    bit  exp_busy;

    task automatic reset_model();
        m_pend   = '0;
        m_rq     = '0;
        m_last   = N - 1;
        m_act    = 1'b0;
        m_free   = 0;
        m_sel    = 0;
        m_pick   = 0;
        edge_n   = 0;
        exp_busy = 1'b0;
        exp_kind.delete();
        exp_id.delete();
    endtask

    task automatic push(input int k, input int id);
        exp_kind.push_back(k);
        exp_id.push_back(id);
    endtask

    task automatic model_edge();
        logic [N-1:0] rise;
        bit   [N-1:0] old;
        int           i;
        edge_n++;
        rise = req & ~m_rq;
        m_rq = req;
        old  = m_pend;
        if (m_act) begin
            if (edge_n == m_pick + 1)
                m_pend[m_sel] = 1'b0;
            if (edge_n >= m_pick + 2 && res_done) begin
                push(1, m_sel);
                m_last = m_sel;
                m_act  = 1'b0;
                m_free = edge_n + 2;
            end else if (edge_n == m_pick + 1 + T) begin
                push(2, m_sel);
                m_last = m_sel;
                m_act  = 1'b0;
                m_free = edge_n + 1;
            end
        end else if (edge_n >= m_free && old != 0) begin
            for (int off = 1; off <= N; off++) begin
                i = (m_last + off) % N;
                if (!m_act && old[i]) begin
                    m_act = 1'b1;
                    m_sel = i;
                end
            end
            m_pick    = edge_n;
            m_done_at = edge_n + 2 + int'($urandom_range(0, T + 2));
            push(0, m_sel);
        end
        m_pend   = m_pend | rise;
        exp_busy = m_act || (edge_n < m_free - 1);
    endtask

    task automatic drive(input int rate);
        int nxt;
        nxt = edge_n + 1;
        for (int i = 0; i < N; i++)
            if (rate > 0 && $urandom_range(0, rate) == 0)
                req[i] = ~req[i];
        if (m_act && nxt >= m_pick + 2)
            res_done = (nxt == m_done_at);
        else
            res_done = ($urandom_range(0, 3) == 0);
    endtask

    task automatic step(input int rate);
        @(posedge clk);
        model_edge();
        #1;
        drive(rate);
    endtask

    task automatic chk_zero(input string nm);
        checks++;
        if (ack !== '0 || res_start !== 1'b0 || res_id !== '0 ||
            busy !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL %s: ack=%b start=%b id=%0d busy=%b to=%b, need all 0",
                     nm, ack, res_start, res_id, busy, timeout_err);
        end
    endtask

    task automatic pop_cmp(input int k, input string nm);
        int ek, eid;
        checks++;
        if (exp_kind.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event, id=%0d ack=%b", nm, res_id, ack);
        end else begin
            ek  = exp_kind.pop_front();
            eid = exp_id.pop_front();
            if (ek != k || res_id !== IDW'(eid) ||
                (k == 1 && ack !== N'(1) << eid)) begin
                errors++;
                $display("FAIL %s: kind=%0d id=%0d ack=%b, need kind=%0d id=%0d",
                         nm, k, res_id, ack, ek, eid);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy: got %b need %b at edge %0d", busy, exp_busy, edge_n);
            end
            if (res_start === 1'b1)
                pop_cmp(0, "start");
            if (ack !== '0)
                pop_cmp(1, "ack");
            if (timeout_err === 1'b1)
                pop_cmp(2, "timeout");
            if (exp_kind.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL missing: kind=%0d id=%0d not seen at edge %0d",
                         exp_kind[0], exp_id[0], edge_n);
                exp_kind.delete();
                exp_id.delete();
            end
        end
    end

    int waited;

    initial begin
        rst      = 1'b1;
        req      = '0;
        res_done = 1'b0;
        reset_model();
        #12;
        chk_zero("reset");
        req[0] = 1'b1;
        @(negedge clk);
        #2;
        rst = 1'b0;
        for (int c = 0; c < 1500; c++)
            step((c % 300 < 150) ? 5 : 20);

        // Reset in the middle of a WAIT
        waited = 0;
        while (!(m_act && edge_n >= m_pick + 3) && waited < 300) begin
            step(6);
            waited++;
        end
        if (waited >= 300) begin
            checks++;
            errors++;
            $display("FAIL wait_job: no job in WAIT within %0d cycles", waited);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("async_reset");
        res_done = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_zero("held_reset");
        @(negedge clk);
        #2;
        rst = 1'b0;
        reset_model();

        for (int c = 0; c < 2500; c++)
            step((c % 400 < 200) ? 3 : 12);
        for (int c = 0; c < 150; c++)
            step(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
